// File: rtl/mariokart_pkg.sv
// Shared constants and types for the kart input and motion path.
// Headings, motion state encoding, screen geometry and kart sprite defaults.
package mariokart_pkg;

  localparam int unsigned SCREEN_W       = 640;
  localparam int unsigned SCREEN_H       = 480;
  localparam int unsigned KART_W_DEFAULT = 16;
  localparam int unsigned KART_H_DEFAULT = 16;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    StStopped = 2'd0,
    StAccel   = 2'd1,
    StCoast   = 2'd2,
    StBrake   = 2'd3
  } kart_state_e;

  // Saturating subtract toward zero for the 3-bit speed value.
  function automatic logic [2:0] sat_dec(input logic [2:0] v, input logic [2:0] amt);
    return (v > amt) ? (v - amt) : 3'd0;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button conditioner: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle pulse on each debounced 0->1 transition.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam logic [15:0] CntLast = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        rise_q, rise_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    // Any cycle of agreement falls through with the counter cleared.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/kart_input_controller.sv
// Conditions the four kart buttons and integrates them once per frame into
// position, heading, speed and motion state. Define KART_WRAP_EN for wrap-around edges.
module kart_input_controller
  import mariokart_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned X_MAX           = 639,
  parameter int unsigned Y_MAX           = 479,
  parameter int unsigned KART_W          = KART_W_DEFAULT,
  parameter int unsigned KART_H          = KART_H_DEFAULT,
  parameter int unsigned MAX_SPEED       = 7,
  parameter int unsigned X_INIT          = 312,
  parameter int unsigned Y_INIT          = 400
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       up_button,
  input  logic       down_button,
  input  logic       left_button,
  input  logic       right_button,
  input  logic       frame_tick,
  output logic [9:0] kart_x,
  output logic [9:0] kart_y,
  output logic [1:0] kart_dir,
  output logic [2:0] kart_speed,
  output logic [1:0] kart_state
);

  localparam logic signed [10:0] XLim   = signed'(11'(X_MAX - KART_W + 1));
  localparam logic signed [10:0] YLim   = signed'(11'(Y_MAX - KART_H + 1));
  localparam logic [2:0]         MaxSpd = 3'(MAX_SPEED);

  logic up_lvl, dn_lvl, left_lvl, right_lvl;
  logic up_rise, dn_rise, rise_l, rise_r;
  logic unused_dbnc;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_up (
    .clk_i  (clock),
    .rst_ni (reset),
    .btn_i  (up_button),
    .level_o(up_lvl),
    .rise_o (up_rise)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_down (
    .clk_i  (clock),
    .rst_ni (reset),
    .btn_i  (down_button),
    .level_o(dn_lvl),
    .rise_o (dn_rise)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_left (
    .clk_i  (clock),
    .rst_ni (reset),
    .btn_i  (left_button),
    .level_o(left_lvl),
    .rise_o (rise_l)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_right (
    .clk_i  (clock),
    .rst_ni (reset),
    .btn_i  (right_button),
    .level_o(right_lvl),
    .rise_o (rise_r)
  );

  assign unused_dbnc = ^{up_rise, dn_rise, left_lvl, right_lvl};

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [1:0]  dir_q, dir_d;
  logic [2:0]  spd_q, spd_d;
  logic [1:0]  fc_q, fc_d;
  kart_state_e st_q, st_d;

  logic               vertical, toward_zero, wall_hit;
  logic signed [10:0] pos_s, step_s, lim_s, np_s, npc_s;

  // Candidate position along the current heading, before edge handling.
  always_comb begin
    vertical    = (dir_q == DIR_UP) || (dir_q == DIR_DOWN);
    toward_zero = (dir_q == DIR_UP) || (dir_q == DIR_LEFT);
    step_s      = signed'({8'd0, spd_q});
    pos_s       = vertical ? signed'({1'b0, y_q}) : signed'({1'b0, x_q});
    lim_s       = vertical ? YLim : XLim;
    np_s        = toward_zero ? (pos_s - step_s) : (pos_s + step_s);
    npc_s       = np_s;
    wall_hit    = 1'b0;
`ifdef KART_WRAP_EN
    if (np_s < 11'sd0) begin
      npc_s = lim_s + np_s;
    end else if (np_s > lim_s) begin
      npc_s = np_s - lim_s - 11'sd1;
    end
`else
    if (np_s < 11'sd0) begin
      npc_s    = 11'sd0;
      wall_hit = 1'b1;
    end else if (np_s > lim_s) begin
      npc_s    = lim_s;
      wall_hit = 1'b1;
    end
`endif
  end

  always_comb begin
    dir_d = dir_q;
    x_d   = x_q;
    y_d   = y_q;
    spd_d = spd_q;
    fc_d  = fc_q;
    st_d  = st_q;

    case ({rise_r, rise_l})
      2'b10:   dir_d = dir_q + 2'd1;
      2'b01:   dir_d = dir_q - 2'd1;
      default: dir_d = dir_q;
    endcase

    if (frame_tick) begin
      fc_d = fc_q + 2'd1;
      if (vertical) begin
        y_d = npc_s[9:0];
      end else begin
        x_d = npc_s[9:0];
      end

      if (dn_lvl) begin
        spd_d = sat_dec(spd_q, 3'd2);
        st_d  = StBrake;
      end else if (up_lvl) begin
        spd_d = (spd_q < MaxSpd) ? (spd_q + 3'd1) : MaxSpd;
        st_d  = StAccel;
      end else begin
        if (fc_q == 2'd3) begin
          spd_d = sat_dec(spd_q, 3'd1);
        end
        st_d = StCoast;
      end

      if ((spd_d == 3'd0) && !up_lvl) begin
        st_d = StStopped;
      end
      if (wall_hit) begin
        spd_d = 3'd0;
        st_d  = StStopped;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q   <= 10'(X_INIT);
      y_q   <= 10'(Y_INIT);
      dir_q <= DIR_UP;
      spd_q <= 3'd0;
      fc_q  <= 2'd0;
      st_q  <= StStopped;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      dir_q <= dir_d;
      spd_q <= spd_d;
      fc_q  <= fc_d;
      st_q  <= st_d;
    end
  end

  assign kart_x     = x_q;
  assign kart_y     = y_q;
  assign kart_dir   = dir_q;
  assign kart_speed = spd_q;
  assign kart_state = st_q;

endmodule

// File: tb/tb_kart_input_controller.sv
// Self-checking bench for kart_input_controller: table-driven frame vectors
// through an expected-value queue, plus hand-written debounce/rotation/wall/reset cases.
module tb_kart_input_controller;

  localparam int unsigned Dbnc   = 16;
  localparam int unsigned Settle = Dbnc + 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       up_button = 1'b0, down_button = 1'b0;
  logic       left_button = 1'b0, right_button = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] kart_x, kart_y;
  logic [1:0] kart_dir;
  logic [2:0] kart_speed;
  logic [1:0] kart_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] dir;
    logic [2:0] spd;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    logic       up;
    logic       dn;
    logic [2:0] spd;
    logic [9:0] y;
    logic [1:0] st;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[26];

  always #5 clock = ~clock;

  kart_input_controller #(.DEBOUNCE_CYCLES(Dbnc)) dut (
    .clock       (clock),
    .reset       (reset),
    .up_button   (up_button),
    .down_button (down_button),
    .left_button (left_button),
    .right_button(right_button),
    .frame_tick  (frame_tick),
    .kart_x      (kart_x),
    .kart_y      (kart_y),
    .kart_dir    (kart_dir),
    .kart_speed  (kart_speed),
    .kart_state  (kart_state)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic tick_expect(input string name, input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    if (sb_q.size() == 0) begin
      check({name, "_queue_empty"}, 1, 0);
    end else begin
      got = sb_q.pop_front();
      check({name, "_x"}, kart_x, got.x);
      check({name, "_y"}, kart_y, got.y);
      check({name, "_dir"}, kart_dir, got.dir);
      check({name, "_spd"}, kart_speed, got.spd);
      check({name, "_st"}, kart_state, got.st);
    end
    step(3);
  endtask

  task automatic tick_only();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(3);
  endtask

  task automatic tap_right();
    right_button = 1'b1;
    step(Settle);
    right_button = 1'b0;
    step(Settle);
  endtask

  initial begin
    int  n, changes, my, ms, ny;
    bit  rose;
    logic cur_up, cur_dn;
    logic [1:0] prev_dir;

    // up/dn, speed, y, state after each tick; x = 312, dir = 0 throughout.
    vecs[0]  = '{1'b1, 1'b0, 3'd1, 10'd400, 2'd1};
    vecs[1]  = '{1'b1, 1'b0, 3'd2, 10'd399, 2'd1};
    vecs[2]  = '{1'b1, 1'b0, 3'd3, 10'd397, 2'd1};
    vecs[3]  = '{1'b1, 1'b0, 3'd4, 10'd394, 2'd1};
    vecs[4]  = '{1'b1, 1'b0, 3'd5, 10'd390, 2'd1};
    vecs[5]  = '{1'b1, 1'b0, 3'd6, 10'd385, 2'd1};
    vecs[6]  = '{1'b1, 1'b0, 3'd7, 10'd379, 2'd1};
    vecs[7]  = '{1'b1, 1'b0, 3'd7, 10'd372, 2'd1};
    vecs[8]  = '{1'b1, 1'b0, 3'd7, 10'd365, 2'd1};
    vecs[9]  = '{1'b1, 1'b0, 3'd7, 10'd358, 2'd1};
    vecs[10] = '{1'b0, 1'b1, 3'd5, 10'd351, 2'd3};
    vecs[11] = '{1'b0, 1'b1, 3'd3, 10'd346, 2'd3};
    vecs[12] = '{1'b0, 1'b1, 3'd1, 10'd343, 2'd3};
    vecs[13] = '{1'b0, 1'b1, 3'd0, 10'd342, 2'd0};
    vecs[14] = '{1'b1, 1'b0, 3'd1, 10'd342, 2'd1};
    vecs[15] = '{1'b1, 1'b0, 3'd2, 10'd341, 2'd1};
    vecs[16] = '{1'b1, 1'b0, 3'd3, 10'd339, 2'd1};
    vecs[17] = '{1'b1, 1'b0, 3'd4, 10'd336, 2'd1};
    // Frame counter sits at 2 here, so coasting drops speed on the 2nd and 6th tick.
    vecs[18] = '{1'b0, 1'b0, 3'd4, 10'd332, 2'd2};
    vecs[19] = '{1'b0, 1'b0, 3'd3, 10'd328, 2'd2};
    vecs[20] = '{1'b0, 1'b0, 3'd3, 10'd325, 2'd2};
    vecs[21] = '{1'b0, 1'b0, 3'd3, 10'd322, 2'd2};
    vecs[22] = '{1'b0, 1'b0, 3'd3, 10'd319, 2'd2};
    vecs[23] = '{1'b0, 1'b0, 3'd2, 10'd316, 2'd2};
    vecs[24] = '{1'b0, 1'b0, 3'd2, 10'd314, 2'd2};
    vecs[25] = '{1'b0, 1'b0, 3'd2, 10'd312, 2'd2};

    step(3);
    check("reset_x", kart_x, 312);
    check("reset_y", kart_y, 400);
    check("reset_dir", kart_dir, 0);
    check("reset_spd", kart_speed, 0);
    check("reset_st", kart_state, 0);
    reset = 1'b1;
    step(2);

    // Short glitches must never get through the debouncer.
    rose = 1'b0;
    for (int c = 0; c < 200; c++) begin
      up_button = ((c % 10) < 5);
      step(1);
      if (dut.u_dbnc_up.level_o) rose = 1'b1;
    end
    up_button = 1'b0;
    step(10);
    check("glitch_no_rise", int'(rose), 0);

    up_button = 1'b1;
    n = 0;
    while (n < 40 && !dut.u_dbnc_up.level_o) begin
      step(1);
      n++;
    end
    check("debounce_latency", n, 18);

    cur_up = 1'b1;
    cur_dn = 1'b0;
    for (int i = 0; i < 26; i++) begin
      if (vecs[i].up != cur_up || vecs[i].dn != cur_dn) begin
        up_button   = vecs[i].up;
        down_button = vecs[i].dn;
        cur_up      = vecs[i].up;
        cur_dn      = vecs[i].dn;
        step(Settle);
      end
      tick_expect($sformatf("vec%0d", i),
                  exp_t'{10'd312, vecs[i].y, 2'd0, vecs[i].spd, vecs[i].st});
    end

    // A held button rotates exactly once; simultaneous left+right cancels.
    right_button = 1'b1;
    changes = 0;
    prev_dir = kart_dir;
    for (int c = 0; c < 100; c++) begin
      step(1);
      if (kart_dir != prev_dir) changes++;
      prev_dir = kart_dir;
    end
    check("right_hold_dir", kart_dir, 1);
    check("right_hold_once", changes, 1);
    right_button = 1'b0;
    step(Settle);
    left_button  = 1'b1;
    right_button = 1'b1;
    step(Settle);
    check("both_dir", kart_dir, 1);
    left_button  = 1'b0;
    right_button = 1'b0;
    step(Settle);
    left_button = 1'b1;
    step(Settle);
    check("left_dir", kart_dir, 0);
    left_button = 1'b0;
    step(Settle);
    check("idle_hold_y", kart_y, 312);
    check("idle_hold_spd", kart_speed, 2);

    // Drive upward into the top edge.
    up_button = 1'b1;
    step(Settle);
    my = 312;
    ms = 2;
    while (my >= ms) begin
      my = my - ms;
      ms = (ms < 7) ? ms + 1 : 7;
      tick_expect("climb", exp_t'{10'd312, 10'(my), 2'd0, 3'(ms), 2'd1});
    end
    ny = my - ms;
`ifdef KART_WRAP_EN
    tick_expect("edge_wrap", exp_t'{10'd312, 10'(464 + ny), 2'd0, 3'd7, 2'd1});
`else
    tick_expect("edge_clamp", exp_t'{10'd312, 10'd0, 2'd0, 3'd0, 2'd0});
`endif

    // Turn to face down, build speed, then reset asynchronously mid-frame.
    tap_right();
    tap_right();
    check("turn_down_dir", kart_dir, 2);
    repeat (5) tick_only();
`ifdef KART_WRAP_EN
    check("pre_reset_spd", kart_speed, 7);
`else
    check("pre_reset_spd", kart_speed, 5);
`endif
    step(2);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_x", kart_x, 312);
    check("async_rst_y", kart_y, 400);
    check("async_rst_dir", kart_dir, 0);
    check("async_rst_spd", kart_speed, 0);
    check("async_rst_st", kart_state, 0);
    up_button = 1'b0;
    step(3);
    check("rst_hold_spd", kart_speed, 0);
    check("rst_dbnc_up", int'(dut.u_dbnc_up.level_o), 0);
    reset = 1'b1;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
